// File: rtl/i2c_byte_feeder.sv
// Byte queue that feeds an I2C master one byte at a time: a small circular FIFO
// drained in bursts by a load/kick/wait/gap sequencer with timeout and sticky errors.
module i2c_byte_feeder #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     go,
    input  logic                     err_clr,
    input  logic                     m_done,
    output logic                     m_start,
    output logic [7:0]               m_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     burst_done,
    output logic                     ovf_err,
    output logic                     tmo_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] TMO_ONE   = CW'(1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_KICK   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [CW-1:0]   r_tmo_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_m_done_d;
    logic            r_m_start;
    logic [7:0]      r_m_data;
    logic            r_busy;
    logic            r_burst_done;
    logic            r_ovf_err;
    logic            r_tmo_err;

    logic            w_full;
    logic            w_empty;
    logic            w_rise;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_tmo;

    assign w_full    = (r_count == CNT_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_rise    = m_done & ~r_m_done_d;
    assign w_pop     = (r_state == ST_LOAD) && !w_empty;
    // A timeout flush wins over a concurrent write; the pop in LOAD frees a slot when full.
    assign w_tmo     = (r_state == ST_WAIT) && !w_rise && (r_tmo_cnt == TMO_LAST);
    assign w_push    = wr_en && (!w_full || w_pop) && !w_tmo;
    assign w_ovf_set = wr_en && w_full && !w_pop;

    // Next-state decode for the burst sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (go && !w_empty) begin
                    w_next = ST_LOAD;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_LOAD:   w_next = ST_KICK;
            ST_KICK:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (w_rise) begin
                    w_next = w_empty ? ST_FINISH : ST_GAP;
                end else if (w_tmo) begin
                    w_next = ST_FINISH;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_next = ST_LOAD;
                end else begin
                    w_next = ST_GAP;
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_m_start    <= 1'b0;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
            r_m_done_d   <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_m_start    <= (w_next == ST_KICK);
            r_busy       <= (w_next != ST_IDLE);
            r_burst_done <= (w_next == ST_FINISH);
            r_m_done_d   <= m_done;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_m_data <= 8'h00;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_m_data <= r_mem[r_rptr];
            end
            if (w_tmo) begin
                r_rptr  <= r_wptr;
                r_count <= '0;
            end else begin
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Wait-timeout and inter-byte gap counters; both restart whenever their state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_tmo_cnt <= (r_state == ST_WAIT) ? r_tmo_cnt + TMO_ONE : '0;
            r_gap_cnt <= (r_state == ST_GAP)  ? r_gap_cnt + GAP_ONE : '0;
        end
    end

    // Sticky error flags; a new error takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end else if (err_clr) begin
                r_tmo_err <= 1'b0;
            end
        end
    end

    assign m_start    = r_m_start;
    assign m_data     = r_m_data;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign busy       = r_busy;
    assign burst_done = r_burst_done;
    assign ovf_err    = r_ovf_err;
    assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_i2c_byte_feeder.sv
// Directed self-checking bench for i2c_byte_feeder (DEPTH=4, GAP_CYCLES=2, TIMEOUT=1024).
module tb_i2c_byte_feeder;

    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       go = 1'b0;
    logic       err_clr = 1'b0;
    logic       m_done = 1'b0;
    logic       m_start;
    logic [7:0] m_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       burst_done;
    logic       ovf_err;
    logic       tmo_err;

    int checks = 0;
    int failures = 0;

    i2c_byte_feeder dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .go(go),
        .err_clr(err_clr), .m_done(m_done), .m_start(m_start), .m_data(m_data),
        .full(full), .empty(empty), .count(count), .busy(busy),
        .burst_done(burst_done), .ovf_err(ovf_err), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (m_start !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, m_start, 1);
    endtask

    task automatic send_ack(input logic [7:0] exp, input string tag);
        wait_start(tag);
        chk({tag, "_data"}, m_data, exp);
        repeat (3) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
    endtask

    task automatic wait_burst_done(input string tag);
        int n = 0;
        int starts = 0;
        while (burst_done !== 1'b1 && n < 60) begin
            tick();
            if (m_start === 1'b1) starts++;
            n++;
        end
        chk({tag, "_burst_done"}, burst_done, 1);
        chk({tag, "_extra_starts"}, starts, 0);
    endtask

    initial begin
        int extra;
        int seen_bd;
        logic [7:0] exp_q [5];

        // Reset state
        repeat (3) tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_errs", {ovf_err, tmo_err, burst_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two-byte burst with timing checks
        push(8'hA5);
        push(8'h3C);
        chk("t1_count2", count, 2);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t1_load_busy", busy, 1);
        chk("t1_load_nostart", m_start, 0);
        tick();
        chk("t1_start1", m_start, 1);
        chk("t1_data1", m_data, 8'hA5);
        chk("t1_count1", count, 1);
        extra = 0;
        repeat (20) begin
            tick();
            if (m_start === 1'b1) extra++;
        end
        chk("t1_single_pulse", extra, 0);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        tick();
        chk("t1_gap_nostart", m_start, 0);
        tick();
        chk("t1_start2", m_start, 1);
        chk("t1_data2", m_data, 8'h3C);
        repeat (20) tick();
        chk("t1_data_hold", m_data, 8'h3C);
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("t1_burst_done", burst_done, 1);
        chk("t1_count0", count, 0);
        tick();
        chk("t1_bd_pulse", burst_done, 0);
        chk("t1_idle", busy, 0);

        // Overflow, error clear priority, drain without the dropped byte
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("t2_full", full, 1);
        chk("t2_no_ovf", ovf_err, 0);
        push(8'h77);
        chk("t2_ovf", ovf_err, 1);
        chk("t2_count4", count, 4);
        wr_en = 1'b1;
        wr_data = 8'h77;
        err_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        err_clr = 1'b0;
        chk("t2_set_beats_clr", ovf_err, 1);
        chk("t2_count_still4", count, 4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_ovf_clr", ovf_err, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        send_ack(8'h11, "t2_b0");
        send_ack(8'h22, "t2_b1");
        send_ack(8'h33, "t2_b2");
        send_ack(8'h44, "t2_b3");
        wait_burst_done("t2");
        tick();

        // Write on the LOAD cycle while full
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 4; i++) push(exp_q[i]);
        go = 1'b1;
        tick();
        go = 1'b0;
        wr_en = 1'b1;
        wr_data = exp_q[4];
        tick();
        wr_en = 1'b0;
        chk("t3_count4", count, 4);
        chk("t3_no_ovf", ovf_err, 0);
        chk("t3_start", m_start, 1);
        for (int i = 0; i < 5; i++) send_ack(exp_q[i], $sformatf("t3_b%0d", i));
        wait_burst_done("t3");
        tick();

        // Timeout with m_done held low
        push(8'h5A);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        chk("t4_start", m_start, 1);
        repeat (TMO) tick();
        chk("t4_not_yet", tmo_err, 0);
        tick();
        chk("t4_tmo", tmo_err, 1);
        chk("t4_burst_done", burst_done, 1);
        chk("t4_count0", count, 0);
        tick();
        chk("t4_idle", busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_tmo_clr", tmo_err, 0);

        // Asynchronous reset mid-burst
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        chk("t5_wait_count", count, 2);
        chk("t5_wait_data", m_data, 8'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_flags", {empty, full, busy, m_start, burst_done}, 5'b10000);
        chk("t5_rst_data", m_data, 8'h00);
        chk("t5_rst_errs", {ovf_err, tmo_err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        seen_bd = 0;
        repeat (50) begin
            tick();
            if (m_start === 1'b1) extra++;
            if (burst_done === 1'b1) seen_bd++;
        end
        chk("t5_no_start", extra, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (10) begin
            tick();
            if (burst_done === 1'b1 || busy === 1'b1) seen_bd++;
        end
        chk("t5_empty_go", seen_bd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_byte_feeder.md
I2C_BYTE_FEEDER -- requirements
Module: i2c_byte_feeder

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 4, FIFO entries (power of 2, >=2).
- GAP_CYCLES, 2, idle cycles between consecutive bytes (>=1).
- TIMEOUT, 1024, max cycles waiting for m_done per byte (>=2).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, push wr_data into FIFO.
- wr_data, in, 8, byte to queue.
- go, in, 1, start draining FIFO to the I2C master.
- err_clr, in, 1, clear sticky error flags.
- m_done, in, 1, done from downstream i2c_master (level).
- m_start, out, 1, one-cycle start pulse to i2c_master.
- m_data, out, 8, byte presented to i2c_master data_in.
- full, out, 1, FIFO full.
- empty, out, 1, FIFO empty.
- count, out, log2(DEPTH)+1, FIFO occupancy.
- busy, out, 1, burst in progress.
- burst_done, out, 1, one-cycle pulse at burst end.
- ovf_err, out, 1, sticky: write while full.
- tmo_err, out, 1, sticky: m_done timeout.

Function
REQ-003 The FIFO SHALL be circular, DEPTH entries, with wrapping read/write pointers; count = writes minus pops.
REQ-004 A wr_en while full SHALL be dropped and set ovf_err; count and contents SHALL be unchanged.
REQ-005 A push and a pop in the same cycle SHALL both take effect; count SHALL be unchanged, and this SHALL be legal when full.
REQ-006 The FSM states SHALL be IDLE, LOAD, KICK, WAIT, GAP, FINISH.
REQ-007 In IDLE, go=1 with !empty SHALL go to LOAD; go=1 with empty SHALL be ignored (no burst_done).
REQ-008 LOAD SHALL pop the FIFO head into the m_data register, then go to KICK.
REQ-009 KICK SHALL drive m_start=1 for exactly one cycle, then go to WAIT.
REQ-010 m_data SHALL be held stable from LOAD until the next LOAD.
REQ-011 WAIT SHALL complete on a rising edge of m_done (m_done=1 now, 0 previous cycle); a level already high on WAIT entry SHALL NOT count.
REQ-012 On completion, WAIT SHALL go to GAP if !empty, else to FINISH; emptiness is sampled on the completion cycle, so bytes written during the burst are sent.
REQ-013 GAP SHALL last exactly GAP_CYCLES cycles, then go to LOAD.
REQ-014 The WAIT timeout counter SHALL reset on WAIT entry. After TIMEOUT cycles without completion it SHALL set tmo_err, flush the FIFO (count=0), and go to FINISH.
REQ-015 FINISH SHALL pulse burst_done for one cycle, then go to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 go while busy SHALL be ignored.
REQ-018 Latency: go (IDLE, !empty) at cycle N SHALL give LOAD at N+1 and m_start high at N+2.
REQ-019 err_clr SHALL clear both sticky flags; if err_clr and a new error occur in the same cycle, the flag SHALL be set.
REQ-020 full and empty SHALL be derived from count and SHALL be valid in the same cycle as count.

Reset
REQ-021 rst_n low SHALL immediately and asynchronously force:
- state IDLE, pointers 0, count 0, empty 1, full 0;
- m_start 0, m_data 8'h00, busy 0, burst_done 0;
- ovf_err 0, tmo_err 0, timeout and gap counters 0, m_done edge register 0.
REQ-022 Reset asserted mid-burst SHALL discard queued bytes; after release no m_start SHALL occur until a new go.

Verification
REQ-023 Push A5, 3C, then go; model m_done as a 1-cycle pulse 20 cycles after each m_start -> m_start at go+2 with m_data=A5; second m_start exactly GAP_CYCLES+2 cycles after the first done, with m_data=3C; burst_done one cycle after the second done; count=0.
REQ-024 Push 4 bytes (full=1), push a 5th (77) -> ovf_err=1, count=4, 77 never appears on m_data; err_clr -> ovf_err=0.
REQ-025 Push 1 byte, go, hold m_done low -> tmo_err=1 after TIMEOUT cycles in WAIT, burst_done pulses, busy=0.
REQ-026 With full FIFO during a burst, wr_en on the LOAD cycle -> write accepted, count stays 4, ovf_err=0; all 5 bytes are sent in order.
REQ-027 Assert rst_n=0 while in WAIT with 2 bytes queued -> all outputs immediately take reset values; after release plus 50 cycles, no m_start; go with empty -> no burst_done.
